// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: steps each instruction through
// FETCH, DECODE, EXEC and WB, decodes the opcode into datapath controls,
// raises single-cycle strobes and counts retired instructions.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for start, all outputs quiet
// FETCH  | imem_req high until imem_ack; opcode latched on ack
// DECODE | controls driven from latched opcode; HALT opcode exits here
// EXEC   | ALU runs, alu_zero captured for the branch decision
// WB     | register write / PC update strobes, retired count advances
// HALT   | stopped until reset, start ignored
module multicycle_sequencer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             imem_req,
   input  logic             imem_ack,
   input  logic [5:0]       instr_op,
   input  logic             alu_zero,
   output logic             ir_load,
   output logic [2:0]       ALUCtrl,
   output logic             alu_src_imm,
   output logic             operand_swap,
   output logic             rf_we,
   output logic             pc_inc,
   output logic             pc_branch,
   output logic             halted,
   output logic             busy,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [5:0] OP_BEQ  = 6'd10;
   localparam logic [5:0] OP_ADDI = 6'd11;
   localparam logic [5:0] OP_HALT = 6'd63;

   state_t           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic             taken_q, taken_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic [2:0] dec_alu;
   logic       dec_imm;
   logic       dec_swap;
   logic       dec_we;
   logic       dec_branch;

   // Sequencer registers; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= 6'd0;
         taken_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         taken_q   <= taken_d;
         retired_q <= retired_d;
      end
   end

   // Opcode decode of the latched instruction into the control set.
   always_comb begin
      dec_alu    = 3'd0;
      dec_imm    = 1'b0;
      dec_swap   = 1'b0;
      dec_we     = 1'b0;
      dec_branch = 1'b0;
      case (op_q)
         6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: begin
            dec_alu = op_q[2:0];
            dec_we  = 1'b1;
         end
         OP_BEQ: begin
            dec_imm    = 1'b1;
            dec_swap   = 1'b1;
            dec_branch = 1'b1;
         end
         OP_ADDI: begin
            dec_imm = 1'b1;
            dec_we  = 1'b1;
         end
         OP_HALT: begin
            dec_we = 1'b0;
         end
         default: begin
            // Unknown opcodes behave as a register-register add.
            dec_we = 1'b1;
         end
      endcase
   end

   // Next-state logic and Moore strobes (ir_load also follows imem_ack).
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      taken_d      = taken_q;
      retired_d    = retired_q;
      imem_req     = 1'b0;
      ir_load      = 1'b0;
      ALUCtrl      = 3'd0;
      alu_src_imm  = 1'b0;
      operand_swap = 1'b0;
      rf_we        = 1'b0;
      pc_inc       = 1'b0;
      pc_branch    = 1'b0;
      halted       = 1'b0;
      busy         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
         end
         S_FETCH: begin
            busy     = 1'b1;
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_load = 1'b1;
               op_d    = instr_op;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            busy         = 1'b1;
            ALUCtrl      = dec_alu;
            alu_src_imm  = dec_imm;
            operand_swap = dec_swap;
            state_d      = (op_q == OP_HALT) ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            busy         = 1'b1;
            ALUCtrl      = dec_alu;
            alu_src_imm  = dec_imm;
            operand_swap = dec_swap;
            taken_d      = alu_zero;
            state_d      = S_WB;
         end
         S_WB: begin
            busy         = 1'b1;
            ALUCtrl      = dec_alu;
            alu_src_imm  = dec_imm;
            operand_swap = dec_swap;
            rf_we        = dec_we;
            if (dec_branch && taken_q) pc_branch = 1'b1;
            else                       pc_inc    = 1'b1;
            retired_d    = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d      = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign retired = retired_q;

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle sequencer for the single-issue CPU datapath. It steps each instruction through FETCH, DECODE, EXEC and WB. It decodes the 6-bit opcode into the existing ALU/branch/write-enable control set and raises one-cycle strobes for the instruction register, ALU, register file and PC. It sits between the instruction-memory port and the datapath, and it counts retired instructions.

## Interface
- CNT_W, 16, width of the retired-instruction counter
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  leave IDLE and begin fetching
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch complete; instr_op valid this cycle
- instr_op  in  6  opcode field of fetched instruction
- alu_zero  in  1  ALU zero flag, sampled in EXEC
- ir_load  out  1  load instruction register
- ALUCtrl  out  3  ALU operation
- alu_src_imm  out  1  ALU operand B = immediate
- operand_swap  out  1  swap register read operands
- rf_we  out  1  register-file write strobe
- pc_inc  out  1  PC <= PC+1
- pc_branch  out  1  PC <= branch target
- halted  out  1  sequencer stopped by HALT opcode
- busy  out  1  state is not IDLE and not HALT
- retired  out  CNT_W  instructions completed, wraps

## Operation
- States and transitions:
  - IDLE: go to FETCH when start=1.
  - FETCH: go to DECODE when imem_ack=1.
  - DECODE: go to HALT if the latched op is 63, otherwise go to EXEC.
  - EXEC: always go to WB.
  - WB: always go to FETCH.
  - HALT: stays in HALT until rst.
- FETCH:
  - imem_req=1 for every cycle spent in FETCH.
  - On the imem_ack cycle: ir_load=1 and instr_op is latched into the internal op_q.
  - instr_op is ignored when imem_ack=0.
- Decode of op_q (held through DECODE, EXEC and WB):
  - op 0..5: ALUCtrl=op[2:0], register operands, writes result.
  - op 10 (BEQ): ALUCtrl=0, alu_src_imm=1, operand_swap=1, no write, branch.
  - op 11 (ADDI): ALUCtrl=0, alu_src_imm=1, writes result.
  - op 63 (HALT): no ALU action, no write, no PC update.
  - All other ops: decoded as op 0 (ALU add, register operands, writes result).
- ALUCtrl, alu_src_imm and operand_swap are driven during DECODE, EXEC and WB; they are 0 in every other state.
- EXEC: alu_zero is registered into taken_q; only op 10 uses it.
- WB:
  - rf_we=1 for writing ops.
  - op 10 with taken_q=1: pc_branch=1. Every other non-HALT op: pc_inc=1.
  - Exactly one of pc_inc/pc_branch per retired instruction.
  - retired increments by 1 and wraps from 2^CNT_W−1 to 0.
- HALT: halted=1, busy=0, all strobes 0. start is ignored. retired does not count the HALT instruction.
- start asserted outside IDLE: ignored.

## Timing
- Reset, all synchronous:
  - state=IDLE, op_q=0, taken_q=0, retired=0.
  - All outputs 0.
  - Reset has priority over all other inputs in the same cycle.
- Reset mid-instruction: in-flight instruction aborted. No rf_we, pc_inc or pc_branch on the cycle after the reset edge.
- ir_load, rf_we, pc_inc and pc_branch are single-cycle pulses, combinational from state (Moore outputs, plus imem_ack for ir_load).
- Latency:
  - With imem_ack in the first FETCH cycle, an instruction takes 4 cycles (FETCH, DECODE, EXEC, WB).
  - Each cycle of ack delay adds one FETCH cycle.
- Cycle after start (IDLE): first FETCH. Cycle after WB: next FETCH (imem_req high again).
- retired updates on the edge closing WB and is visible in the following cycle.
- HALT is entered on the edge closing DECODE; halted is high from the next cycle onward.

## Test plan
- Reset, then start=1 for 1 cycle, op=1, immediate ack, alu_zero=0 → IDLE→FETCH→DECODE→EXEC→WB. Expect ALUCtrl=1 in DECODE/EXEC/WB, rf_we=1 and pc_inc=1 only in WB, retired=1 after 4 cycles.
- BEQ op=10 with alu_zero=1 in EXEC → WB has pc_branch=1, pc_inc=0, rf_we=0, operand_swap=1, alu_src_imm=1. Repeat with alu_zero=0 → pc_inc=1, pc_branch=0.
- Fetch stall: imem_ack held low 3 cycles → imem_req high 4 cycles, ir_load exactly once on the ack cycle, instruction spans 7 cycles total.
- Opcodes 11, 7 and 63 back-to-back:
  - op 11: alu_src_imm=1 with rf_we.
  - op 7: behaves as op 0 (ALUCtrl=0, rf_we=1).
  - op 63: halted=1, busy=0, no further imem_req, start ignored, retired=2.
- Assert rst during EXEC of op 0 → no rf_we/pc_inc on any later cycle, all outputs 0, retired=0. A new start restarts normally.
- CNT_W=4: retire 17 instructions → retired wraps 15→0 and reads 1.
